// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Instruction-memory, redirect and decode-side signal bundle
//                of the fetch queue.
//  Revision    : 1.0
// ============================================================================
interface fetch_queue_if #(
    parameter int DATA_SIZE = 32,
    parameter int MEM_SIZE  = 8
);
    logic                 imem_req;
    logic [MEM_SIZE-1:0]  imem_addr;
    logic                 imem_ack;
    logic [DATA_SIZE-1:0] imem_rdata;
    logic                 redirect;
    logic [MEM_SIZE-1:0]  redirect_pc;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [DATA_SIZE-1:0] instr;
    logic [MEM_SIZE-1:0]  instr_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Single-outstanding instruction fetcher feeding a prefetch
//                FIFO, with redirect flush and in-flight discard.
//                Optional stall counter enabled by FETCH_STALL_CNT_EN.
//  Revision    : 1.0
// ============================================================================
module fetch_queue #(
    parameter int DATA_SIZE  = 32,
    parameter int MEM_SIZE   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          core_clk,
    input  logic          resetn,
    fetch_queue_if.master bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MEM_SIZE-1:0] r_pc;
    logic [MEM_SIZE-1:0] w_pc_nxt;
    logic [MEM_SIZE-1:0] r_req_addr;
    logic [MEM_SIZE-1:0] w_req_addr_nxt;

    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_valid;

    logic [DATA_SIZE-1:0] r_data_mem [FIFO_DEPTH];
    logic [MEM_SIZE-1:0]  r_pc_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]     r_count;

    // ------------------------------------------------------------------
    // Fetch FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_req_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM: next state. r_req_addr keeps the in-flight address so
    // that r_pc may already move to a redirect target during DISCARD.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_push         = 1'b0;
        w_flush        = bus.redirect;

        case (r_state)
            ST_IDLE: begin
                if (bus.redirect) begin
                    w_pc_nxt = bus.redirect_pc;
                end else if (r_count < c_full_count) begin
                    w_state_nxt    = ST_WAIT;
                    w_req_addr_nxt = r_pc;
                end
            end

            ST_WAIT: begin
                if (bus.imem_ack) begin
                    w_state_nxt = ST_IDLE;
                    if (bus.redirect) begin
                        w_pc_nxt = bus.redirect_pc;
                    end else begin
                        w_push   = 1'b1;
                        w_pc_nxt = r_pc + MEM_SIZE'(1);
                    end
                end else if (bus.redirect) begin
                    w_state_nxt = ST_DISCARD;
                    w_pc_nxt    = bus.redirect_pc;
                end
            end

            ST_DISCARD: begin
                if (bus.redirect) begin
                    w_pc_nxt = bus.redirect_pc;
                end
                if (bus.imem_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.imem_req  = (r_state != ST_IDLE);
    assign bus.imem_addr = bus.imem_req ? r_req_addr : '0;

    // ------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & bus.instr_ready & ~bus.redirect;

    always_ff @(posedge core_clk) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge core_clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= bus.imem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_pc;
        end
    end

    assign bus.instr_valid = w_valid;
    assign bus.instr       = w_valid ? r_data_mem[r_rd_ptr] : '0;
    assign bus.instr_pc    = w_valid ? r_pc_mem[r_rd_ptr]   : '0;

`ifdef FETCH_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Decode-starvation counter, saturating
    // ------------------------------------------------------------------
    logic [15:0] r_stall_cnt;

    always_ff @(posedge core_clk) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (!w_valid && bus.instr_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Scoreboard bench for fetch_queue with a latency-programmable
//                instruction memory model.
//  Revision    : 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int DW = 32;
    localparam int AW = 8;

    logic core_clk;
    logic resetn;

    fetch_queue_if #(.DATA_SIZE(DW), .MEM_SIZE(AW)) bus ();

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fetch_queue #(.DATA_SIZE(DW), .MEM_SIZE(AW), .FIFO_DEPTH(4)) dut (
        .core_clk (core_clk),
        .resetn   (resetn),
        .bus      (bus)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [AW+DW-1:0] sb[$];
    logic [AW-1:0]    req_log[$];
    logic [AW-1:0]    pop_pc[$];
    int               pop_cyc[$];
    logic [15:0]      pop_stall[$];

    int          ack_delay = 0;
    int          wait_cnt  = 0;
    bit          drop_pending = 0;
    bit          mem_en = 1;
    logic [15:0] resp_cnt = 16'h0100;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge core_clk);
            #1;
        end
    endtask

    always @(posedge core_clk) cyc++;

    // Memory model: acks ack_delay cycles after a request first appears and
    // predicts whether the fetched word will reach decode.
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge core_clk);
            #2;
            if (!resetn) begin
                bus.imem_ack = 1'b0;
                wait_cnt     = 0;
                drop_pending = 0;
            end else if (bus.imem_req && mem_en) begin
                if (wait_cnt == 0) req_log.push_back(bus.imem_addr);
                if (wait_cnt >= ack_delay) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = {8'hA5, bus.imem_addr, resp_cnt};
                    resp_cnt++;
                    if (!drop_pending && !bus.redirect)
                        sb.push_back({bus.imem_addr, bus.imem_rdata});
                    drop_pending = 0;
                    wait_cnt     = 0;
                end else begin
                    bus.imem_ack = 1'b0;
                    wait_cnt++;
                    if (bus.redirect) drop_pending = 1;
                end
            end else begin
                bus.imem_ack = 1'b0;
            end
        end
    end

    // Decode-side monitor: every accepted head is compared with the scoreboard.
    always @(negedge core_clk) begin
        if (!resetn) begin
            sb.delete();
        end else begin
            if (bus.instr_valid && bus.instr_ready) begin
                pop_pc.push_back(bus.instr_pc);
                pop_cyc.push_back(cyc);
`ifdef FETCH_STALL_CNT_EN
                pop_stall.push_back(stall_cnt);
`endif
                if (sb.size() == 0)
                    check("sb_underrun", 64'(sb.size()), 64'd1);
                else
                    check("head", 64'({bus.instr_pc, bus.instr}), 64'(sb.pop_front()));
            end
            if (bus.redirect) sb.delete();
        end
    end

    task automatic clear_logs();
        req_log.delete();
        pop_pc.delete();
        pop_cyc.delete();
        pop_stall.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        clear_logs();
    endtask

    initial begin
        int n;
        resetn          = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;

        // Reset state
        step(3);
        check("rst_req",   64'(bus.imem_req),    64'd0);
        check("rst_addr",  64'(bus.imem_addr),   64'd0);
        check("rst_valid", 64'(bus.instr_valid), 64'd0);
        check("rst_instr", 64'(bus.instr),       64'd0);
        check("rst_pc",    64'(bus.instr_pc),    64'd0);
`ifdef FETCH_STALL_CNT_EN
        check("rst_stall", 64'(stall_cnt),       64'd0);
`endif

        // Streaming fetch, zero-wait memory
        bus.instr_ready = 1'b1;
        resetn = 1'b1;
        clear_logs();
        step(1);
        check("first_req",  64'(bus.imem_req),  64'd1);
        check("first_addr", 64'(bus.imem_addr), 64'd0);
        n = 0;
        while (pop_pc.size() < 4 && n < 40) begin step(1); n++; end
        check("stream_timeout", 64'(n < 40), 64'd1);
        for (int i = 0; i < 4 && i < pop_pc.size(); i++) begin
            check("stream_pc", 64'(pop_pc[i]), 64'(i));
            if (i > 0) check("stream_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd2);
        end

        // Back-pressure fills the queue to exactly four
        bus.instr_ready = 1'b0;
        do_reset();
        step(20);
        check("full_sb",    64'(sb.size()),       64'd4);
        check("full_reqs",  64'(req_log.size()),  64'd4);
        check("full_req",   64'(bus.imem_req),    64'd0);
        check("full_valid", 64'(bus.instr_valid), 64'd1);
        check("full_head",  64'(bus.instr_pc),    64'd0);
        bus.instr_ready = 1'b1;
        step(12);
        check("drain_order", 64'(pop_pc.size() >= 4 ? pop_pc[3] : 8'hEE), 64'd3);

        // Redirect while the request for pc 5 is outstanding
        ack_delay = 2;
        do_reset();
        n = 0;
        while (!(bus.imem_req && bus.imem_addr == 8'h05) && n < 60) begin step(1); n++; end
        check("rd5_timeout", 64'(n < 60), 64'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h40;
        step(1);
        bus.redirect = 1'b0;
        check("discard_req",  64'(bus.imem_req),  64'd1);
        check("discard_addr", 64'(bus.imem_addr), 64'd5);
        req_log.delete();
        n = 0;
        while (req_log.size() < 1 && n < 30) begin step(1); n++; end
        check("redir_addr", 64'(req_log.size() > 0 ? req_log[0] : 8'hEE), 64'h40);
        n = 0;
        while (!bus.instr_valid && n < 30) begin step(1); n++; end
        check("redir_head", 64'(bus.instr_pc), 64'h40);

        // Redirect coinciding with an ack, then wrap-around fetch
        ack_delay = 0;
        bus.instr_ready = 1'b0;
        n = 0;
        while (!(bus.imem_req && sb.size() >= 2) && n < 40) begin step(1); n++; end
        check("ackredir_timeout", 64'(n < 40), 64'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFE;
        step(1);
        bus.redirect = 1'b0;
        check("flush_valid", 64'(bus.instr_valid), 64'd0);
        check("flush_instr", 64'(bus.instr),       64'd0);
        check("flush_pc",    64'(bus.instr_pc),    64'd0);
        req_log.delete();
        bus.instr_ready = 1'b1;
        n = 0;
        while (req_log.size() < 3 && n < 30) begin step(1); n++; end
        check("wrap_a0", 64'(req_log.size() > 0 ? req_log[0] : 8'hEE), 64'hFE);
        check("wrap_a1", 64'(req_log.size() > 1 ? req_log[1] : 8'hEE), 64'hFF);
        check("wrap_a2", 64'(req_log.size() > 2 ? req_log[2] : 8'hEE), 64'h00);
        step(6);

        // Reset mid-request with three entries queued
        ack_delay = 5;
        bus.instr_ready = 1'b0;
        do_reset();
        n = 0;
        while (!(bus.imem_req && sb.size() == 3) && n < 80) begin step(1); n++; end
        check("midrst_timeout", 64'(n < 80), 64'd1);
        resetn = 1'b0;
        step(1);
        check("midrst_req",   64'(bus.imem_req),    64'd0);
        check("midrst_addr",  64'(bus.imem_addr),   64'd0);
        check("midrst_valid", 64'(bus.instr_valid), 64'd0);
        check("midrst_instr", 64'(bus.instr),       64'd0);
        check("midrst_pc",    64'(bus.instr_pc),    64'd0);
        resetn = 1'b1;
        clear_logs();
        step(1);
        check("refetch_req",  64'(bus.imem_req),  64'd1);
        check("refetch_addr", 64'(bus.imem_addr), 64'd0);

`ifdef FETCH_STALL_CNT_EN
        // Starvation counting and saturation
        ack_delay = 2;
        bus.instr_ready = 1'b1;
        do_reset();
        n = 0;
        while (pop_stall.size() < 4 && n < 60) begin step(1); n++; end
        for (int i = 1; i < 4 && i < pop_stall.size(); i++)
            check("stall_step", 64'(pop_stall[i] - pop_stall[i-1]), 64'd3);
        mem_en = 0;
        step(70000);
        check("stall_sat", 64'(stall_cnt), 64'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_SIZE, default 32, SHALL set the instruction word width.
REQ-002 Parameter MEM_SIZE, default 8, SHALL set the instruction address width; PC space is 2^MEM_SIZE words.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two >= 2, SHALL set the prefetch queue depth.
REQ-004 core_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 resetn  in  1  SHALL be a synchronous, active-low reset.
REQ-006 imem_req  out  1  SHALL be the fetch request to instruction memory.
REQ-007 imem_addr  out  MEM_SIZE  SHALL be the word address of the request.
REQ-008 imem_ack  in  1  SHALL be the one-cycle memory response strobe.
REQ-009 imem_rdata  in  DATA_SIZE  SHALL be the instruction word, valid only when imem_ack=1.
REQ-010 redirect  in  1  SHALL be the branch/jump flush strobe from the downstream core.
REQ-011 redirect_pc  in  MEM_SIZE  SHALL be the new fetch address, sampled when redirect=1.
REQ-012 instr_valid  out  1  SHALL indicate the queue head holds an instruction.
REQ-013 instr_ready  in  1  SHALL be the decode-stage accept signal.
REQ-014 instr  out  DATA_SIZE  SHALL be the queue-head instruction.
REQ-015 instr_pc  out  MEM_SIZE  SHALL be the address of the queue-head instruction.

Function
REQ-016 FSM states SHALL be IDLE (no request), WAIT (request outstanding), DISCARD (outstanding request whose data is to be dropped).
REQ-017 IDLE->WAIT when queue count < FIFO_DEPTH and redirect=0; imem_req=1, imem_addr=pc in WAIT and DISCARD, imem_req=0 in IDLE.
REQ-018 At most one request outstanding; imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-019 WAIT with imem_ack=1, redirect=0: push {pc, imem_rdata}, pc <= pc+1 modulo 2^MEM_SIZE (MEM_SIZE'(-1) wraps to 0), go IDLE.
REQ-020 Pushed data SHALL appear at instr/instr_valid the cycle after imem_ack (1-cycle latency); a new request SHALL issue no earlier than that same cycle.
REQ-021 Handshake: an entry is consumed on a cycle with instr_valid=1 and instr_ready=1; instr/instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; push SHALL never occur at count=FIFO_DEPTH; pop SHALL never occur when empty.
REQ-023 redirect=1 SHALL empty the queue and load pc <= redirect_pc in that cycle, overriding any push or pop; a handshake in that cycle counts as consumed by decode.
REQ-024 redirect in WAIT without imem_ack SHALL go DISCARD; DISCARD holds the old request until imem_ack, drops the data, then goes IDLE.
REQ-025 redirect coinciding with imem_ack SHALL drop the data and go IDLE; redirect in DISCARD SHALL only update pc.
REQ-026 Request for redirect_pc SHALL issue on the cycle after the old request completes (or after redirect, if none outstanding).
REQ-027 When empty, instr and instr_pc SHALL be 0.

Reset
REQ-028 resetn=0 at a core_clk edge SHALL set state IDLE, pc=0, queue empty, imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, stall_cnt=0 (when present).
REQ-029 Reset mid-request SHALL abandon the request; an imem_ack during or after reset while IDLE SHALL be ignored.
REQ-030 First request (imem_addr=0) SHALL be asserted in the first cycle after the first edge with resetn=1.

Configuration
REQ-031 With FETCH_STALL_CNT_EN defined: output stall_cnt (16 bits) SHALL increment each cycle instr_valid=0 and instr_ready=1, saturate at 16'hFFFF, clear only on reset.
REQ-032 Without FETCH_STALL_CNT_EN: port stall_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset release, memory acks 1 cycle after each req, instr_ready=1 -> instr_pc sequence 0,1,2,3 with matching imem_rdata, no gaps beyond the 2-cycle fetch loop.
REQ-034 instr_ready=0 for 20 cycles -> exactly 4 entries (pc 0..3) queued, imem_req stays 0 once full, no overflow; release -> drains in order.
REQ-035 redirect_pc=8'h40 while request for pc 5 outstanding -> ack for 5 discarded, next imem_addr=8'h40, first instr_pc after redirect=8'h40.
REQ-036 redirect_pc=8'hFE with ack on same cycle -> queue empty next cycle, fetches 8'hFE, 8'hFF, 8'h00 (wrap).
REQ-037 resetn=0 for one cycle while in WAIT with 3 entries queued -> all outputs 0 next cycle, refetch from pc 0.
REQ-038 With FETCH_STALL_CNT_EN, ack delay 3 cycles, instr_ready=1 -> stall_cnt rises by 3 per instruction; forced 70000 starve cycles -> stall_cnt=16'hFFFF.
